// File: rtl/mesi_isc_tb_stim_gen.sv
// Parametrised stimulus generator for the MESI ISC bench: CPU_COUNT
// independent channels each issue NUM_INS pseudo-random RD/WR instructions
// with random NOP gaps, plus completion detection, a per-channel hang
// watchdog and a running count of accepted instructions.
//
// Handshake: while a channel is in ISSUE it holds tb_ins/tb_ins_addr stable
// (valid = non-NOP); the instruction is accepted on the first rising edge
// where tb_ins_ack is high. Acks seen while the channel shows NOP are ignored.
module mesi_isc_tb_stim_gen #(
    parameter int          CPU_COUNT      = 4,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          ADDR_LINE_BITS = 2,
    parameter int          NUM_INS        = 16,
    parameter int          GAP_BITS       = 2,
    parameter int          TIMEOUT        = 1024,
    parameter logic [31:0] SEED           = 32'h1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start_i,
    input  logic [CPU_COUNT-1:0]                     tb_ins_ack_i,
    output logic [4*CPU_COUNT-1:0]                   tb_ins_o,
    output logic [ADDR_WIDTH*CPU_COUNT-1:0]          tb_ins_addr_o,
    output logic                                     done_o,
    output logic [CPU_COUNT-1:0]                     error_o,
    output logic [$clog2(CPU_COUNT*NUM_INS+1)-1:0]   issued_cnt_o,
    output logic [3*CPU_COUNT-1:0]                   dbg_state_o
);

    localparam int          CNT_W   = $clog2(CPU_COUNT*NUM_INS+1);
    localparam int          IC_W    = $clog2(NUM_INS+1);
    localparam int          GAP_W   = GAP_BITS + 1;
    localparam int          WD_W    = $clog2(TIMEOUT+1);
    localparam logic [31:0] TAPS    = 32'h80200003;
    localparam logic [3:0]  OP_NOP  = 4'd0;
    localparam logic [3:0]  OP_WR   = 4'd1;
    localparam logic [3:0]  OP_RD   = 4'd2;
    localparam logic [IC_W-1:0]  CNT_LAST = IC_W'(NUM_INS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_HUNG  = 3'd4
    } state_t;

    logic [CPU_COUNT-1:0] w_accept_vec;
    logic [CPU_COUNT-1:0] w_term_vec;
    logic [CNT_W-1:0]     w_acc_sum;
    logic [CNT_W-1:0]     r_issued;

    for (genvar ch = 0; ch < CPU_COUNT; ch++) begin : g_ch
        // Zero would lock the LFSR, so it is swapped for 1.
        localparam logic [31:0] SEED_RAW = SEED ^ 32'(ch);
        localparam logic [31:0] SEED_CH  = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

        state_t                r_state, w_state_nxt;
        logic [31:0]           r_lfsr, w_lfsr_nxt, w_lfsr_adv;
        logic [3:0]            r_op, w_op_nxt, w_dec_op;
        logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt, w_dec_addr;
        logic [IC_W-1:0]       r_count, w_count_nxt;
        logic [GAP_W-1:0]      r_gap, w_gap_nxt, w_dec_gap;
        logic [WD_W-1:0]       r_wd, w_wd_nxt;
        logic                  r_error, w_error_nxt;
        logic                  w_accept;

        // Galois step and field decode of the advanced LFSR value; the
        // instruction and the gap preceding it come from the same value.
        assign w_lfsr_adv = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'd0);
        assign w_dec_op   = w_lfsr_adv[0] ? OP_WR : OP_RD;
        assign w_dec_addr = ADDR_WIDTH'(w_lfsr_adv[ADDR_LINE_BITS+1:2]);
        assign w_dec_gap  = GAP_W'(w_lfsr_adv[31 -: GAP_BITS]) + GAP_W'(1);

        // Next-state and datapath update for this channel.
        always_comb begin
            w_state_nxt = r_state;
            w_lfsr_nxt  = r_lfsr;
            w_op_nxt    = r_op;
            w_addr_nxt  = r_addr;
            w_count_nxt = r_count;
            w_gap_nxt   = r_gap;
            w_wd_nxt    = r_wd;
            w_error_nxt = r_error;
            w_accept    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = S_ISSUE;
                        w_lfsr_nxt  = w_lfsr_adv;
                        w_op_nxt    = w_dec_op;
                        w_addr_nxt  = w_dec_addr;
                        w_wd_nxt    = '0;
                    end
                end
                S_ISSUE: begin
                    if (tb_ins_ack_i[ch]) begin
                        w_accept    = 1'b1;
                        w_count_nxt = r_count + IC_W'(1);
                        w_lfsr_nxt  = w_lfsr_adv;
                        if (r_count == CNT_LAST) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_op_nxt    = w_dec_op;
                            w_addr_nxt  = w_dec_addr;
                            w_gap_nxt   = w_dec_gap;
                        end
                    end else if (r_wd == WD_LAST) begin
                        w_state_nxt = S_HUNG;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_wd_nxt = r_wd + WD_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(1)) begin
                        w_state_nxt = S_ISSUE;
                        w_wd_nxt    = '0;
                    end else begin
                        w_gap_nxt = r_gap - GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // Channel registers; reset aborts any in-flight instruction.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= S_IDLE;
                r_lfsr  <= SEED_CH;
                r_op    <= OP_NOP;
                r_addr  <= '0;
                r_count <= '0;
                r_gap   <= '0;
                r_wd    <= '0;
                r_error <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_lfsr  <= w_lfsr_nxt;
                r_op    <= w_op_nxt;
                r_addr  <= w_addr_nxt;
                r_count <= w_count_nxt;
                r_gap   <= w_gap_nxt;
                r_wd    <= w_wd_nxt;
                r_error <= w_error_nxt;
            end
        end

        assign tb_ins_o[4*ch +: 4]                    = (r_state == S_ISSUE) ? r_op : OP_NOP;
        assign tb_ins_addr_o[ADDR_WIDTH*ch +: ADDR_WIDTH] = (r_state == S_ISSUE) ? r_addr : '0;
        assign error_o[ch]                            = r_error;
        assign w_accept_vec[ch]                       = w_accept;
        assign w_term_vec[ch]                         = (r_state == S_DONE) || (r_state == S_HUNG);
        assign dbg_state_o[3*ch +: 3]                 = r_state;
    end

    // Popcount of this cycle's accepted acks across all channels.
    always_comb begin
        w_acc_sum = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            w_acc_sum = w_acc_sum + CNT_W'(w_accept_vec[i]);
        end
    end

    // Running total of accepted instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issued <= '0;
        end else begin
            r_issued <= r_issued + w_acc_sum;
        end
    end

    assign issued_cnt_o = r_issued;
    assign done_o       = &w_term_vec;

endmodule

// File: tb/tb_mesi_isc_tb_stim_gen.sv
// Bench for mesi_isc_tb_stim_gen: 4 channels, SEED=0 (channel 0 falls back
// to seed 1), TIMEOUT=8. A reference LFSR fills per-channel expected queues;
// a monitor pops and compares every issued instruction and its NOP gap.
module tb_mesi_isc_tb_stim_gen;

    localparam int NCH  = 4;
    localparam int NINS = 16;
    localparam int AW   = 32;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [NCH-1:0]    ack;
    logic [4*NCH-1:0]  tb_ins_o;
    logic [AW*NCH-1:0] tb_ins_addr_o;
    logic              done_o;
    logic [NCH-1:0]    error_o;
    logic [6:0]        issued_cnt_o;
    logic [3*NCH-1:0]  dbg_state_o;

    mesi_isc_tb_stim_gen #(
        .CPU_COUNT(NCH), .ADDR_WIDTH(AW), .ADDR_LINE_BITS(2), .NUM_INS(NINS),
        .GAP_BITS(2), .TIMEOUT(8), .SEED(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .tb_ins_ack_i(ack),
        .tb_ins_o(tb_ins_o), .tb_ins_addr_o(tb_ins_addr_o), .done_o(done_o),
        .error_o(error_o), .issued_cnt_o(issued_cnt_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [38:0] exp_q[NCH][$];   // {gap_before[2:0], op[3:0], addr[31:0]}
    logic [3:0]  first_op[NCH];
    logic [31:0] first_addr[NCH];
    int          ack_mode[NCH];   // 0 never, 1 two cycles after issue, 2 always
    int          hold[NCH];
    logic        mon_en = 1'b0;
    logic [3:0]  prev_op[NCH];
    logic [31:0] prev_addr[NCH];
    logic        prev_err[NCH];
    logic        first_seen[NCH];
    int          nop_run[NCH];
    int          seen[NCH];
    int          entry_cyc[NCH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ 32'h80200003;
        return v >> 1;
    endfunction

    // Reference sequence for every channel, seed = 0 ^ ch with 0 -> 1.
    task automatic fill_queues();
        logic [31:0] v;
        logic [2:0]  g;
        logic [3:0]  op;
        logic [31:0] a;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_q[ch].delete();
            v = 32'(ch);
            if (v == 32'd0) v = 32'd1;
            v = ref_step(v);
            for (int k = 0; k < NINS; k++) begin
                g  = (k == 0) ? 3'd0 : 3'(v[31:30]) + 3'd1;
                op = v[0] ? 4'd1 : 4'd2;
                a  = {30'd0, v[3:2]};
                if (k == 0) begin
                    first_op[ch]   = op;
                    first_addr[ch] = a;
                end
                exp_q[ch].push_back({g, op, a});
                v = ref_step(v);
            end
        end
    endtask

    task automatic clear_tracking();
        for (int ch = 0; ch < NCH; ch++) begin
            prev_op[ch]    = 4'd0;
            prev_addr[ch]  = 32'd0;
            prev_err[ch]   = 1'b0;
            first_seen[ch] = 1'b1;
            nop_run[ch]    = 0;
            seen[ch]       = 0;
            entry_cyc[ch]  = 0;
            hold[ch]       = 0;
        end
    endtask

    // ---------------- ack responder (CPU model stand-in) ----------------
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            case (ack_mode[ch])
                0: ack[ch] = 1'b0;
                2: ack[ch] = 1'b1;
                default: begin
                    if (tb_ins_o[4*ch +: 4] != 4'd0) begin
                        hold[ch]++;
                        ack[ch] = (hold[ch] >= 2);
                    end else begin
                        hold[ch] = 0;
                        ack[ch]  = 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor: pop and compare ----------------
    always @(negedge clk) begin
        logic [3:0]  cur_op;
        logic [31:0] cur_addr;
        logic [38:0] e;
        if (mon_en) begin
            for (int ch = 0; ch < NCH; ch++) begin
                cur_op   = tb_ins_o[4*ch +: 4];
                cur_addr = tb_ins_addr_o[AW*ch +: AW];
                if (cur_op != 4'd0 && prev_op[ch] == 4'd0) begin
                    seen[ch]++;
                    entry_cyc[ch] = cyc;
                    check($sformatf("queue_nonempty_ch%0d", ch), 64'(exp_q[ch].size() != 0), 64'd1);
                    if (exp_q[ch].size() != 0) begin
                        e = exp_q[ch].pop_front();
                        check($sformatf("op_ch%0d_n%0d", ch, seen[ch]), 64'(cur_op), 64'(e[35:32]));
                        check($sformatf("addr_ch%0d_n%0d", ch, seen[ch]), 64'(cur_addr), 64'(e[31:0]));
                        if (!first_seen[ch])
                            check($sformatf("gap_ch%0d_n%0d", ch, seen[ch]), 64'(nop_run[ch]), 64'(e[38:36]));
                    end
                    first_seen[ch] = 1'b0;
                    nop_run[ch]    = 0;
                end else if (cur_op != 4'd0) begin
                    check($sformatf("stable_op_ch%0d", ch), 64'(cur_op), 64'(prev_op[ch]));
                    check($sformatf("stable_addr_ch%0d", ch), 64'(cur_addr), 64'(prev_addr[ch]));
                end else if (!first_seen[ch]) begin
                    nop_run[ch]++;
                end
                if (error_o[ch] && !prev_err[ch])
                    check($sformatf("hang_latency_ch%0d", ch), 64'(cyc - entry_cyc[ch]), 64'd8);
                prev_op[ch]   = cur_op;
                prev_addr[ch] = cur_addr;
                prev_err[ch]  = error_o[ch];
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic check_zero_outputs(input string tag);
        check({tag, "_ins"},   64'(tb_ins_o), 64'd0);
        check({tag, "_addr"},  64'(tb_ins_addr_o), 64'd0);
        check({tag, "_done"},  64'(done_o), 64'd0);
        check({tag, "_err"},   64'(error_o), 64'd0);
        check({tag, "_cnt"},   64'(issued_cnt_o), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 64'(done_o), 64'd1);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        mon_en  = 1'b0;
        start_i = 1'b0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_and_start();
        clear_tracking();
        fill_queues();
        rst     = 1'b1;
        mon_en  = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("first_op_ch%0d", ch), 64'(tb_ins_o[4*ch +: 4]), 64'(first_op[ch]));
            check($sformatf("first_addr_ch%0d", ch), 64'(tb_ins_addr_o[AW*ch +: AW]), 64'(first_addr[ch]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst     = 1'b0;
        start_i = 1'b0;
        ack     = '0;
        for (int ch = 0; ch < NCH; ch++) ack_mode[ch] = 1;
        clear_tracking();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // Idle with start low must not issue anything.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", 64'(tb_ins_o), 64'd0);

        // Run 1: channel 2 never acks and hangs; the rest complete.
        enter_reset();
        ack_mode[2] = 0;
        release_and_start();
        wait_done(2000);
        check("run1_cnt", 64'(issued_cnt_o), 64'd48);
        check("run1_err", 64'(error_o), 64'b0100);
        for (int ch = 0; ch < NCH; ch++)
            check($sformatf("run1_seen_ch%0d", ch), 64'(seen[ch]), (ch == 2) ? 64'd1 : 64'd16);

        // Run 2: ack held high; all channels accept on the same edge.
        enter_reset();
        check_zero_outputs("reset2");
        for (int ch = 0; ch < NCH; ch++) ack_mode[ch] = 2;
        release_and_start();
        check("simul_before", 64'(issued_cnt_o), 64'd0);
        @(negedge clk);
        check("simul_after", 64'(issued_cnt_o), 64'd4);
        check("simul_nop", 64'(tb_ins_o), 64'd0);
        wait_done(2000);
        check("run2_cnt", 64'(issued_cnt_o), 64'd64);
        check("run2_err", 64'(error_o), 64'd0);
        for (int ch = 0; ch < NCH; ch++)
            check($sformatf("run2_seen_ch%0d", ch), 64'(seen[ch]), 64'd16);

        // Run 3: asynchronous reset mid-flight, then a clean restart.
        enter_reset();
        for (int ch = 0; ch < NCH; ch++) ack_mode[ch] = 1;
        release_and_start();
        repeat (12) @(negedge clk);
        check("midrun_progress", 64'(issued_cnt_o != 0), 64'd1);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        release_and_start();
        wait_done(2000);
        check("run3_cnt", 64'(issued_cnt_o), 64'd64);
        check("run3_err", 64'(error_o), 64'd0);
        for (int ch = 0; ch < NCH; ch++)
            check($sformatf("run3_seen_ch%0d", ch), 64'(seen[ch]), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_isc_tb_stim_gen.md
# mesi_isc_tb_stim_gen

Parametrised stimulus generator for the MESI ISC testbench. It replaces fixed four-CPU instruction driving with CPU_COUNT independent channels. Each channel issues NUM_INS pseudo-random RD/WR instructions to its mesi_isc_tb_cpu instance over the tb_ins/tb_ins_ack handshake, inserting random NOP gaps between them. It adds completion detection, a per-channel hang watchdog and an accepted-instruction counter, none of which the fixed bench has.

## Interface
- CPU_COUNT, 4: number of channels (1..16).
- ADDR_WIDTH, 32: tb_ins_addr width per channel.
- ADDR_LINE_BITS, 2: number of random low address bits; the upper bits are zero. The small range forces sharing between CPUs.
- NUM_INS, 16: instructions issued per channel (>=1).
- GAP_BITS, 2: random gap field width; gap = 1 + field, giving 1..2^GAP_BITS cycles.
- TIMEOUT, 1024: cycles in ISSUE without ack before a channel is declared hung.
- SEED, 32'h1: LFSR base seed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- start_i  in  1  level; sampled in IDLE.
- tb_ins_ack_i  in  CPU_COUNT  per-channel ack from the CPU model.
- tb_ins_o  out  4*CPU_COUNT  instruction per channel: NOP=4'd0, WR=4'd1, RD=4'd2.
- tb_ins_addr_o  out  ADDR_WIDTH*CPU_COUNT  address per channel.
- done_o  out  1  all channels in DONE or HUNG.
- error_o  out  CPU_COUNT  sticky per-channel hang flag.
- issued_cnt_o  out  $clog2(CPU_COUNT*NUM_INS+1)  total accepted instructions.

## Operation
Each channel has a 32-bit Galois LFSR (taps 32'h80200003).
- Seed = SEED ^ channel index; a zero seed is replaced by 1.
- The LFSR advances once on IDLE->ISSUE and once on each accepted ack.

Fields taken from the current LFSR value:
- lfsr[0]: 0 selects RD, 1 selects WR.
- lfsr[ADDR_LINE_BITS+1:2]: address.
- lfsr[31:32-GAP_BITS]: gap field.

Per-channel states:
- IDLE: outputs NOP and address 0. start_i=1 moves to ISSUE with the first instruction.
- ISSUE: tb_ins_o and tb_ins_addr_o are driven from the latched instruction and stay stable until ack. The watchdog increments each cycle.
  - ack=1: the count increments. If count reaches NUM_INS, go to DONE. Otherwise latch the gap and next instruction, then go to GAP.
  - watchdog reaches TIMEOUT-1 without ack: go to HUNG and set error_o[ch].
- GAP: outputs NOP; the gap counter decrements. At 1, go to ISSUE and reload the watchdog to 0.
- DONE / HUNG: outputs NOP. Terminal until reset.

Other rules:
- An ack outside ISSUE is ignored.
- start_i outside IDLE is ignored.
- issued_cnt_o adds the popcount of accepted acks each cycle, so simultaneous acks on several channels are all counted.
- done_o is combinational from state: the AND over channels of (DONE|HUNG).

## Timing
- Reset (asynchronous assert): all channels go to IDLE.
  - tb_ins_o=0, tb_ins_addr_o=0, done_o=0, error_o=0, issued_cnt_o=0.
  - LFSRs reload their seeds; the count, gap and watchdog counters clear.
- Reset asserted mid-operation aborts immediately. An instruction in ISSUE is dropped and not counted.
- start_i high at edge N gives the first instruction on tb_ins_o at N+1.
- Ack sampled at edge M gives NOP at M+1. The next instruction appears at M+1+gap, so there is at least 1 NOP cycle between instructions.
- An ack on the final instruction at edge M gives DONE at M+1. done_o rises in the same cycle as the last channel enters DONE.
- Watchdog: with no ack, HUNG and error_o[ch] appear TIMEOUT cycles after ISSUE entry.

## Test plan
- CPU_COUNT=4, NUM_INS=16, acks 2 cycles after each instruction -> done_o=1, issued_cnt_o=64, error_o=4'b0, every channel shows exactly 16 non-NOP instructions.
- CPU_COUNT=1, SEED=0 -> effective seed 1. First instruction = LFSR(1) decode; the bench reference model matches the full 16-instruction sequence.
- Channel 2 ack tied low, TIMEOUT=8 -> error_o=4'b0100 exactly 8 cycles after its ISSUE entry. The other channels finish, then done_o=1 and issued_cnt_o=48.
- All 4 channels ack on the same edge -> issued_cnt_o increments by 4 on that edge.
- Ack held high continuously -> tb_ins_o alternates instruction / NOP gap. The gap length is always 1..4 and no instruction is double-counted.
- rst asserted low while channels are in ISSUE/GAP -> outputs go 0 without waiting for clk. Releasing rst with start_i=1 reproduces the identical first instruction.
